// File: rtl/datapath_pkg.sv
// Shared constants for the bus-based datapath slice: data width and the
// bus-driver priority order (index 0 wins the bus).
package datapath_pkg;

    localparam int DATAPATH_W = 32;

    // Driver slots, listed from highest to lowest bus priority.
    localparam int N_DRV   = 7;
    localparam int DRV_MDR = 0;
    localparam int DRV_PC  = 1;
    localparam int DRV_IR  = 2;
    localparam int DRV_MAR = 3;
    localparam int DRV_R0  = 4;
    localparam int DRV_R1  = 5;
    localparam int DRV_RY  = 6;

endpackage

// File: rtl/datapath_reg.sv
// One datapath register: synchronous clear to a per-instance reset value,
// otherwise captures d when en is high and holds when en is low.
module datapath_reg
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATAPATH_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over the load enable.
    always_ff @(posedge clock) begin
        if (clear) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath.sv
// Bus-based CPU datapath slice: seven registers sharing one internal bus.
// The bus carries the highest-priority driven register; PC/IR/MAR/MDR fall
// back to their immediate inputs when nothing drives the bus.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATAPATH_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             pci,
    input  logic             pco,
    input  logic             iri,
    input  logic             iro,
    input  logic             mari,
    input  logic             maro,
    input  logic             mdri,
    input  logic             mdro,
    input  logic             ryi,
    input  logic             ryo,
    input  logic             r0i,
    input  logic             r0o,
    input  logic             r1i,
    input  logic             r1o,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] pc_immediate,
    input  logic [WIDTH-1:0] ir_immediate,
    input  logic [WIDTH-1:0] mar_immediate,
    input  logic [WIDTH-1:0] mdr_immediate,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] ir_q,
    output logic [WIDTH-1:0] mar_q,
    output logic [WIDTH-1:0] mdr_q,
    output logic [WIDTH-1:0] r0_q,
    output logic [WIDTH-1:0] r1_q,
    output logic [WIDTH-1:0] ry_q
);

    logic [N_DRV-1:0] oe;
    logic [N_DRV-1:0] ie;
    logic [WIDTH-1:0] q       [N_DRV];
    logic [WIDTH-1:0] d       [N_DRV];
    logic [WIDTH-1:0] rst_val [N_DRV];
    logic             bus_active;

    assign oe[DRV_MDR] = mdro;
    assign oe[DRV_PC]  = pco;
    assign oe[DRV_IR]  = iro;
    assign oe[DRV_MAR] = maro;
    assign oe[DRV_R0]  = r0o;
    assign oe[DRV_R1]  = r1o;
    assign oe[DRV_RY]  = ryo;

    assign ie[DRV_MDR] = mdri;
    assign ie[DRV_PC]  = pci;
    assign ie[DRV_IR]  = iri;
    assign ie[DRV_MAR] = mari;
    assign ie[DRV_R0]  = r0i;
    assign ie[DRV_R1]  = r1i;
    assign ie[DRV_RY]  = ryi;

    assign bus_active = |oe;

    // Priority bus mux: scan from lowest priority up so the highest-priority
    // active driver is the last (winning) assignment.
    always_comb begin
        bus = '0;
        for (int i = N_DRV - 1; i >= 0; i--) begin
            if (oe[i]) begin
                bus = q[i];
            end
        end
    end

    // Load sources: general registers always take the bus; the memory-facing
    // registers take their immediate input only when the bus is idle.
    always_comb begin
        d[DRV_MDR] = bus_active ? bus : mdr_immediate;
        d[DRV_PC]  = bus_active ? bus : pc_immediate;
        d[DRV_IR]  = bus_active ? bus : ir_immediate;
        d[DRV_MAR] = bus_active ? bus : mar_immediate;
        d[DRV_R0]  = bus;
        d[DRV_R1]  = bus;
        d[DRV_RY]  = bus;
    end

    // Reset values: PC and IR come from the boot inputs, the rest clear to zero.
    always_comb begin
        for (int i = 0; i < N_DRV; i++) begin
            rst_val[i] = '0;
        end
        rst_val[DRV_PC] = pc;
        rst_val[DRV_IR] = ir;
    end

    for (genvar g = 0; g < N_DRV; g++) begin : g_reg
        datapath_reg #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clock   (clock),
            .clear   (clear),
            .en      (ie[g]),
            .rst_val (rst_val[g]),
            .d       (d[g]),
            .q       (q[g])
        );
    end

    assign pc_q  = q[DRV_PC];
    assign ir_q  = q[DRV_IR];
    assign mar_q = q[DRV_MAR];
    assign mdr_q = q[DRV_MDR];
    assign r0_q  = q[DRV_R0];
    assign r1_q  = q[DRV_R1];
    assign ry_q  = q[DRV_RY];

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed test-plan steps followed by random cycles,
// all checked against a behavioural register-file model.
module tb_datapath;
    import datapath_pkg::*;

    logic        clock;
    logic        clear;
    logic        pci, pco, iri, iro, mari, maro, mdri, mdro;
    logic        ryi, ryo, r0i, r0o, r1i, r1o;
    logic [31:0] pc, ir;
    logic [31:0] pc_immediate, ir_immediate, mar_immediate, mdr_immediate;
    logic [31:0] bus;
    logic [31:0] pc_q, ir_q, mar_q, mdr_q, r0_q, r1_q, ry_q;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m    [N_DRV];
    logic [31:0] q_arr [N_DRV];

    localparam logic [6:0] B_MDR = 7'(1 << DRV_MDR);
    localparam logic [6:0] B_PC  = 7'(1 << DRV_PC);
    localparam logic [6:0] B_IR  = 7'(1 << DRV_IR);
    localparam logic [6:0] B_MAR = 7'(1 << DRV_MAR);
    localparam logic [6:0] B_R0  = 7'(1 << DRV_R0);
    localparam logic [6:0] B_R1  = 7'(1 << DRV_R1);
    localparam logic [6:0] B_RY  = 7'(1 << DRV_RY);

    datapath dut (
        .clock         (clock),
        .clear         (clear),
        .pci           (pci),
        .pco           (pco),
        .iri           (iri),
        .iro           (iro),
        .mari          (mari),
        .maro          (maro),
        .mdri          (mdri),
        .mdro          (mdro),
        .ryi           (ryi),
        .ryo           (ryo),
        .r0i           (r0i),
        .r0o           (r0o),
        .r1i           (r1i),
        .r1o           (r1o),
        .pc            (pc),
        .ir            (ir),
        .pc_immediate  (pc_immediate),
        .ir_immediate  (ir_immediate),
        .mar_immediate (mar_immediate),
        .mdr_immediate (mdr_immediate),
        .bus           (bus),
        .pc_q          (pc_q),
        .ir_q          (ir_q),
        .mar_q         (mar_q),
        .mdr_q         (mdr_q),
        .r0_q          (r0_q),
        .r1_q          (r1_q),
        .ry_q          (ry_q)
    );

    assign q_arr[DRV_MDR] = mdr_q;
    assign q_arr[DRV_PC]  = pc_q;
    assign q_arr[DRV_IR]  = ir_q;
    assign q_arr[DRV_MAR] = mar_q;
    assign q_arr[DRV_R0]  = r0_q;
    assign q_arr[DRV_R1]  = r1_q;
    assign q_arr[DRV_RY]  = ry_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model bus: first register in priority order whose out-enable is set.
    function automatic logic [31:0] model_bus(input logic [6:0] oe);
        for (int i = 0; i < N_DRV; i++) begin
            if (oe[i]) return m[i];
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] imm_of(input int idx);
        case (idx)
            DRV_PC:  return pc_immediate;
            DRV_IR:  return ir_immediate;
            DRV_MAR: return mar_immediate;
            default: return mdr_immediate;
        endcase
    endfunction

    // Apply one cycle of control, check the bus before the edge, advance the
    // model, then check every register and the bus after the edge.
    task automatic step(input logic [6:0] oe, input logic [6:0] ie, input logic clr);
        logic [31:0] b;
        logic [31:0] nxt [N_DRV];
        mdro = oe[DRV_MDR]; pco = oe[DRV_PC]; iro = oe[DRV_IR]; maro = oe[DRV_MAR];
        r0o  = oe[DRV_R0];  r1o = oe[DRV_R1]; ryo = oe[DRV_RY];
        mdri = ie[DRV_MDR]; pci = ie[DRV_PC]; iri = ie[DRV_IR]; mari = ie[DRV_MAR];
        r0i  = ie[DRV_R0];  r1i = ie[DRV_R1]; ryi = ie[DRV_RY];
        clear = clr;
        #1;
        b = model_bus(oe);
        check("bus_pre", bus, b);
        for (int i = 0; i < N_DRV; i++) nxt[i] = m[i];
        if (clr) begin
            for (int i = 0; i < N_DRV; i++) nxt[i] = 32'h0;
            nxt[DRV_PC] = pc;
            nxt[DRV_IR] = ir;
        end else begin
            for (int i = 0; i < N_DRV; i++) begin
                if (ie[i]) begin
                    if (i == DRV_R0 || i == DRV_R1 || i == DRV_RY || oe != 7'b0)
                        nxt[i] = b;
                    else
                        nxt[i] = imm_of(i);
                end
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N_DRV; i++) m[i] = nxt[i];
        for (int i = 0; i < N_DRV; i++) check($sformatf("reg%0d", i), q_arr[i], m[i]);
        check("bus_post", bus, model_bus(oe));
    endtask

    initial begin
        for (int i = 0; i < N_DRV; i++) m[i] = 32'h0;
        clear = 1'b0;
        {pci, pco, iri, iro, mari, maro, mdri, mdro} = '0;
        {ryi, ryo, r0i, r0o, r1i, r1o} = '0;
        pc = 32'h100;
        ir = 32'hABCD0000;
        pc_immediate = 32'h0; ir_immediate = 32'h0;
        mar_immediate = 32'h0; mdr_immediate = 32'h0;
        @(posedge clock);
        #1;

        // Reset state
        step(7'b0, 7'b0, 1'b1);
        check("rst_pc", pc_q, 32'h100);
        check("rst_ir", ir_q, 32'hABCD0000);
        check("rst_mdr", mdr_q, 32'h0);
        check("rst_r0", r0_q, 32'h0);
        check("rst_bus", bus, 32'h0);

        // Immediate load into MDR, then move to R0
        mdr_immediate = 32'd5;
        step(7'b0, B_MDR, 1'b0);
        check("mdr_imm5", mdr_q, 32'd5);
        step(B_MDR, B_R0, 1'b0);
        check("r0_from_mdr", r0_q, 32'd5);
        check("bus_mdr5", bus, 32'd5);

        // Same path with 6 into R1
        mdr_immediate = 32'd6;
        step(7'b0, B_MDR, 1'b0);
        step(B_MDR, B_R1, 1'b0);
        check("r1_from_mdr", r1_q, 32'd6);

        // Register to register, then drive without loading
        step(B_R0, B_RY, 1'b0);
        check("ry_from_r0", ry_q, 32'd5);
        step(B_R1, 7'b0, 1'b0);
        check("bus_r1", bus, 32'd6);

        // Bus wins over immediate; immediate used with idle bus
        mdr_immediate = 32'h28918000;
        step(7'b0, B_MDR, 1'b0);
        ir_immediate = 32'h0000FFFF;
        step(B_MDR, B_IR, 1'b0);
        check("ir_from_bus", ir_q, 32'h28918000);
        step(7'b0, B_IR, 1'b0);
        check("ir_from_imm", ir_q, 32'h0000FFFF);

        // Priority and fan-out
        mdr_immediate = 32'd7;
        step(7'b0, B_MDR, 1'b0);
        step(B_MDR | B_R0, B_R1 | B_RY, 1'b0);
        check("fan_bus", bus, 32'd7);
        check("fan_r1", r1_q, 32'd7);
        check("fan_ry", ry_q, 32'd7);

        // Self drive and load keeps the value
        step(B_PC, B_PC | B_MAR, 1'b0);
        check("pc_self", pc_q, 32'h100);
        check("mar_from_pc", mar_q, 32'h100);

        // Clear mid-sequence overrides the load
        step(B_MDR, B_R0, 1'b1);
        check("clr_r0", r0_q, 32'h0);
        check("clr_mdr", mdr_q, 32'h0);

        // Random cycles
        for (int n = 0; n < 400; n++) begin
            logic [6:0] oe;
            logic [6:0] ie;
            oe = 7'($urandom) & 7'($urandom) & 7'($urandom);
            ie = 7'($urandom) & 7'($urandom);
            pc = $urandom;
            ir = $urandom;
            pc_immediate  = $urandom;
            ir_immediate  = $urandom;
            mar_immediate = $urandom;
            mdr_immediate = $urandom;
            step(oe, ie, ($urandom_range(0, 31) == 0));
        end

        step(7'b0, 7'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Bus-based 32-bit CPU datapath slice.
- Seven 32-bit registers (PC, IR, MAR, MDR, R0, R1, RY) share one internal bus, driven through per-register out-enables.
- Each register loads from the bus under a per-register in-enable. PC, IR, MAR and MDR can also load from an external "immediate" source, which is how memory data enters.
- Controlled cycle by cycle by an external control unit or FSM. No ALU in this block.

Parameters:
- WIDTH, 32, data width of the bus and every register. Only 32 is required to be supported.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- clear  in  1  synchronous active-high reset
- pci, pco  in  1  PC load enable / PC bus drive
- iri, iro  in  1  IR load enable / IR bus drive
- mari, maro  in  1  MAR load enable / MAR bus drive
- mdri, mdro  in  1  MDR load enable / MDR bus drive
- ryi, ryo  in  1  RY load enable / RY bus drive
- r0i, r0o  in  1  R0 load enable / R0 bus drive
- r1i, r1o  in  1  R1 load enable / R1 bus drive
- pc  in  32  PC value captured on clear
- ir  in  32  IR value captured on clear
- pc_immediate, ir_immediate, mar_immediate, mdr_immediate  in  32  external load sources for PC, IR, MAR, MDR
- bus  out  32  current internal bus value
- pc_q, ir_q, mar_q, mdr_q, r0_q, r1_q, ry_q  out  32  register contents

Behaviour:
- Reset:
  - clear high at a rising edge sets PC<=pc, IR<=ir, and MAR, MDR, R0, R1, RY <= 0.
  - clear overrides every load enable in that cycle.
  - Mid-sequence clear behaves identically.
- Bus (combinational):
  - bus = contents of the highest-priority register whose out-enable is high.
  - Priority: mdro > pco > iro > maro > r0o > r1o > ryo.
  - With no out-enable high, bus = 0.
  - "bus_active" = any out-enable high.
- Load (rising edge, clear low):
  - Each register whose in-enable is high captures a new value.
  - Latency: one edge. The new value is visible on *_q and on bus (if driven) immediately after that edge.
- Load source for R0, R1, RY: always the bus.
- Load source for PC, IR, MAR, MDR: bus if bus_active, else the register's *_immediate input.
- Resulting required cases:
  - mdri with no driver loads mdr_immediate.
  - mdro+iri moves MDR to IR.
- Simultaneous enables:
  - Multiple in-enables in one cycle all load the same bus value.
  - A register both driving and loading (xo and xi) reloads its own value, i.e. it is unchanged.
- Enables held high for several cycles reload every edge. Registers with in-enable low hold their value.
- No wrap-around or arithmetic; values pass through unmodified at full 32 bits.

Decomposition:
- Shared package:
  - WIDTH constant.
  - Localparam encoding of the bus-driver priority order, for use by the bench.
- One sub-module, datapath_reg:
  - WIDTH-bit register with sync clear to a reset-value input.
  - Load enable and data input.
  - Instantiated seven times.
- The bus mux and the immediate-vs-bus source selection stay in the top level.

Test Plan:
- Reset: pc=0x100, ir=0xABCD0000, clear high one edge -> pc_q=0x100, ir_q=0xABCD0000, all other *_q=0, bus=0.
- Immediate load and move:
  - mdr_immediate=5, mdri one edge -> mdr_q=5.
  - Then mdro+r0i one edge -> r0_q=5, bus=5 while mdro is high.
  - Repeat with 6 into r1 -> r1_q=6.
- Register to register: r0o+ryi one edge -> ry_q=5. Then r1o alone -> bus=6 and no register changes.
- Bus-over-immediate:
  - mdr_immediate=0x28918000, mdri one edge; then mdro+iri with ir_immediate=0xFFFF -> ir_q=0x28918000.
  - iri with no driver and ir_immediate=0xFFFF -> ir_q=0xFFFF.
- Priority and fan-out: mdro+r0o both high (mdr=7, r0=5) with r1i+ryi -> bus=7, r1_q=7, ry_q=7.
- Clear mid-sequence: clear asserted together with mdro+r0i -> r0_q=0 and mdr_q=0; the load is ignored.
